// File: rtl/cut_sequencer.sv
// Cut sequencer: runs a timed forward/dwell/reverse/dwell stroke cycle per cut
// request, repeated for the requested stroke count, with abort and forced retract.
module cut_sequencer #(
    parameter int TICK_DIV     = 2500,
    parameter int STROKE_TICKS = 200,
    parameter int RETURN_TICKS = 200,
    parameter int DWELL_TICKS  = 10,
    parameter int STROKE_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cut_i,
    input  logic [STROKE_W-1:0] strokes_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                cut_end_o,
    output logic                aborted_o,
    output logic                en_o,
    output logic                direction_o,
    output logic [STROKE_W-1:0] stroke_cnt_o
);
    localparam int MAXA = (STROKE_TICKS > RETURN_TICKS) ? STROKE_TICKS : RETURN_TICKS;
    localparam int MAXT = (MAXA > DWELL_TICKS) ? MAXA : DWELL_TICKS;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TKW  = (MAXT > 1) ? $clog2(MAXT) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FWD     = 3'd1;
    localparam logic [2:0] S_DWELL_F = 3'd2;
    localparam logic [2:0] S_REV     = 3'd3;
    localparam logic [2:0] S_DWELL_R = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [STROKE_W-1:0] ONE = STROKE_W'(1);

    logic [2:0]          state_q, state_d;
    logic [PW-1:0]       pre_q;
    logic [TKW-1:0]      tk_q, lim_m1;
    logic                cut_q;
    logic                skip_q;      // current stroke's forward phase was cut short
    logic [STROKE_W-1:0] target_q;
    logic                start, tick_end, phase_end, abort_acc;

    assign start    = cut_i & ~cut_q & (state_q == S_IDLE) & ~abort_i;
    assign tick_end = (pre_q == PW'(TICK_DIV - 1));

    // Phase length (in ticks, minus one) for the current state
    always_comb begin
        lim_m1 = '0;
        case (state_q)
            S_FWD:              lim_m1 = TKW'(STROKE_TICKS - 1);
            S_REV:              lim_m1 = TKW'(RETURN_TICKS - 1);
            S_DWELL_F, S_DWELL_R: lim_m1 = TKW'(DWELL_TICKS - 1);
            default:            lim_m1 = '0;
        endcase
    end

    assign phase_end = tick_end && (tk_q == lim_m1);

    // Next-state logic; abort during the forward half forces an immediate retract
    always_comb begin
        state_d   = state_q;
        abort_acc = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_FWD;
            S_FWD, S_DWELL_F: begin
                if (abort_i) begin
                    state_d   = S_REV;
                    abort_acc = 1'b1;
                end else if (phase_end) begin
                    state_d = (state_q == S_FWD) ? S_DWELL_F : S_REV;
                end
            end
            S_REV: begin
                abort_acc = abort_i;
                if (phase_end) state_d = S_DWELL_R;
            end
            S_DWELL_R: begin
                abort_acc = abort_i;
                if (phase_end)
                    state_d = (aborted_o || abort_i || (stroke_cnt_o + ONE) == target_q)
                              ? S_DONE : S_FWD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, timer, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pre_q        <= '0;
            tk_q         <= '0;
            cut_q        <= 1'b0;
            skip_q       <= 1'b0;
            target_q     <= '0;
            busy_o       <= 1'b0;
            cut_end_o    <= 1'b0;
            aborted_o    <= 1'b0;
            en_o         <= 1'b0;
            direction_o  <= 1'b0;
            stroke_cnt_o <= '0;
        end else begin
            cut_q   <= cut_i;
            state_q <= state_d;
            // timer restarts on every state entry so phases never drift
            if (state_d != state_q) begin
                pre_q <= '0;
                tk_q  <= '0;
            end else if (tick_end) begin
                pre_q <= '0;
                tk_q  <= tk_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            if (start) begin
                stroke_cnt_o <= '0;
                target_q     <= (strokes_i == '0) ? ONE : strokes_i;
                aborted_o    <= 1'b0;
                skip_q       <= 1'b0;
            end else begin
                if (abort_acc) aborted_o <= 1'b1;
                if (abort_acc && state_q == S_FWD) skip_q <= 1'b1;
                if (state_q == S_DWELL_R && phase_end && !skip_q)
                    stroke_cnt_o <= stroke_cnt_o + ONE;
            end
            busy_o      <= (state_d != S_IDLE);
            cut_end_o   <= (state_d == S_DONE);
            en_o        <= (state_d == S_FWD) || (state_d == S_REV);
            direction_o <= (state_d == S_REV);
        end
    end
endmodule

// File: tb/tb_cut_sequencer.sv
// Bench for cut_sequencer: directed and random requests checked per cycle
// against a phase-list model of the cut cycle.
module tb_cut_sequencer;
    localparam int TD = 4, ST = 3, RT = 2, DT = 1, SW = 4;
    localparam int FWDC = ST * TD, REVC = RT * TD, DWC = DT * TD;

    logic          clk = 1'b0;
    logic          rst, cut_i, abort_i;
    logic [SW-1:0] strokes_i;
    logic          busy_o, cut_end_o, aborted_o, en_o, direction_o;
    logic [SW-1:0] stroke_cnt_o;

    int checks = 0, errors = 0;
    int exp_q[$];     // per-cycle: 0 off, 1 forward, 2 reverse, 3 done
    int exp_cnt;
    bit exp_ab;

    cut_sequencer #(.TICK_DIV(TD), .STROKE_TICKS(ST), .RETURN_TICKS(RT),
                    .DWELL_TICKS(DT), .STROKE_W(SW)) dut (
        .clk(clk), .rst(rst), .cut_i(cut_i), .strokes_i(strokes_i), .abort_i(abort_i),
        .busy_o(busy_o), .cut_end_o(cut_end_o), .aborted_o(aborted_o), .en_o(en_o),
        .direction_o(direction_o), .stroke_cnt_o(stroke_cnt_o));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected phase list for one request; abt is the cycle (from first forward cycle)
    // during which abort_i is held high, -1 for none.
    task automatic build_model(input int n, input int abt);
        int  tgt, t;
        bit  ab, fc, cut;
        tgt = (n == 0) ? 1 : n;
        t = 0; ab = 0; exp_cnt = 0;
        exp_q.delete();
        for (int s = 0; s < tgt; s++) begin
            fc = 0; cut = 0;
            for (int i = 0; i < FWDC; i++) begin
                exp_q.push_back(1);
                if (t == abt) begin ab = 1; fc = 1; cut = 1; end
                t++;
                if (cut) break;
            end
            if (!cut) begin
                for (int i = 0; i < DWC; i++) begin
                    exp_q.push_back(0);
                    if (t == abt) begin ab = 1; cut = 1; end
                    t++;
                    if (cut) break;
                end
            end
            for (int i = 0; i < REVC; i++) begin
                exp_q.push_back(2);
                if (t == abt) ab = 1;
                t++;
            end
            for (int i = 0; i < DWC; i++) begin
                exp_q.push_back(0);
                if (t == abt) ab = 1;
                t++;
            end
            if (!fc) exp_cnt++;
            if (ab) break;
        end
        exp_q.push_back(3);
        exp_ab = ab;
    endtask

    // Issue one request at the current negedge (cut_q must be 0) and check every cycle.
    task automatic do_req(input int n, input int abt, input bit hold);
        int code;
        build_model(n, abt);
        strokes_i = SW'(n); cut_i = 1'b1; abort_i = 1'b0;
        @(negedge clk);
        strokes_i = SW'($urandom);
        for (int k = 0; k < exp_q.size(); k++) begin
            code = exp_q[k];
            chk("en", en_o, (code == 1 || code == 2));
            chk("dir", direction_o, (code == 2));
            chk("busy", busy_o, 1);
            chk("cut_end", cut_end_o, (code == 3));
            if (code == 3) begin
                chk("stroke_cnt", stroke_cnt_o, exp_cnt);
                chk("aborted", aborted_o, exp_ab);
            end
            abort_i = (k == abt);
            cut_i   = (k < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : hold;
            @(negedge clk);
        end
        abort_i = 1'b0;
        chk("idle_busy", busy_o, 0);
        chk("idle_en", en_o, 0);
        chk("idle_end", cut_end_o, 0);
    endtask

    initial begin
        int n, tgt, abt;
        rst = 1'b1; cut_i = 1'b0; abort_i = 1'b0; strokes_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_end", cut_end_o, 0);
        chk("rst_ab", aborted_o, 0);
        chk("rst_en", en_o, 0);
        chk("rst_dir", direction_o, 0);
        chk("rst_cnt", stroke_cnt_o, 0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1, -1, 0);              // single stroke
        do_req(3, -1, 0);              // three strokes, back-to-back start after DONE
        do_req(0, -1, 0);              // zero treated as one
        do_req(3, 5, 0);               // abort in forward stroke
        do_req(2, FWDC + DWC + 3, 0);  // abort during reverse of stroke 1

        // held high after DONE never retriggers
        do_req(1, -1, 1);
        repeat (3) begin
            @(negedge clk);
            chk("hold_busy", busy_o, 0);
        end
        cut_i = 1'b0;
        @(negedge clk);
        // rise together with abort in idle: no start
        cut_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        repeat (3) begin
            chk("abrise_busy", busy_o, 0);
            chk("abrise_en", en_o, 0);
            @(negedge clk);
        end
        cut_i = 1'b0;
        @(negedge clk);

        // reset in the middle of reverse
        strokes_i = 4'd1; cut_i = 1'b1;
        @(negedge clk);
        repeat (FWDC + DWC + 3) @(negedge clk);
        chk("midrev_en", en_o, 1);
        chk("midrev_dir", direction_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cut_i = 1'b0;
        chk("mrst_en", en_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_end", cut_end_o, 0);
        chk("mrst_cnt", stroke_cnt_o, 0);
        repeat (30) begin
            @(negedge clk);
            chk("mrst_quiet", {busy_o, cut_end_o, en_o}, 0);
        end
        do_req(1, -1, 0);

        // random requests
        for (int r = 0; r < 14; r++) begin
            n   = $urandom_range(0, 4);
            tgt = (n == 0) ? 1 : n;
            abt = ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, 28 * tgt - 2);
            do_req(n, abt, 0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
